// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and rotating first-set search for arb4_rr
package arb_pkg;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // Walks start, start+1, ... (mod NREQ); scanning backwards lets the
    // smallest offset overwrite any later candidate.
    function automatic pick_t rr_first(input logic [NREQ-1:0] v, input logic [ID_W-1:0] start);
        pick_t           r;
        logic [ID_W-1:0] k;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = start + ID_W'(i);
            if (v[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_gnt_dec.sv
// rtl/arb_gnt_dec.sv - 2-to-4 grant decoder with enable
module arb_gnt_dec
    import arb_pkg::*;
(
    input  logic [ID_W-1:0] gnt_id,
    input  logic            gnt_vld,
    output logic [NREQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (gnt_vld) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// rtl/arb4_rr.sv - four-requester round-robin arbiter; ARB_TIMEOUT_EN adds hold timeout
module arb4_rr
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld,
    output logic            expire
);

    state_t          state_q, state_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    pick_t           pick;
    logic            take;

`ifdef ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            expire_q, expire_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
`endif

    arb_gnt_dec u_gnt_dec (
        .gnt_id  (gnt_id_q),
        .gnt_vld (gnt_vld_q),
        .gnt     (gnt)
    );

    // Masking the current owner means one search serves both a fresh grant
    // and a handover/revocation; when idle gnt is zero so nothing is masked.
    assign pick = rr_first(req & ~gnt, ptr_q);

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
        take      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        expire_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                take = pick.found;
            end
            BUSY: begin
                if (req[gnt_id_q]) begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (pick.found) begin
                            take     = 1'b1;
                            expire_d = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end else if (pick.found) begin
                    take = 1'b1;
                end else begin
                    gnt_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                gnt_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        if (take) begin
            state_d   = BUSY;
            gnt_id_d  = pick.idx;
            gnt_vld_d = 1'b1;
            ptr_d     = pick.idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            expire_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            expire_q   <= expire_d;
`endif
        end
    end

    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
    assign expire = expire_q;
`else
    assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_arb4_rr.sv
// tb/tb_arb4_rr.sv - self-checking bench for arb4_rr (honours ARB_TIMEOUT_EN)
module tb_arb4_rr;

    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       expire;

    always #5 clk = ~clk;

    arb4_rr #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .expire  (expire)
    );

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_exp   = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int exp_pulses  = 0;

    function automatic int first_from(input logic [3:0] v, input int start);
        for (int i = 0; i < 4; i++) begin
            if (v[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    // m_held counts cycles the owner has already had the grant.
    task automatic model_edge(input logic [3:0] r, input logic rn);
        int w;
        logic [3:0] others;
        m_exp = 1'b0;
        if (!rn) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            return;
        end
        w = -1;
        if (m_owner < 0) begin
            w = first_from(r, m_ptr);
        end else if (r[m_owner]) begin
            others = r;
            others[m_owner] = 1'b0;
            if (TIMEOUT && m_held >= MAX_HOLD && others != 0) begin
                w = first_from(others, m_ptr);
                m_exp = 1'b1;
            end else begin
                m_held = m_held + 1;
                return;
            end
        end else begin
            w = first_from(r, m_ptr);
        end
        m_owner = w;
        if (w >= 0) begin
            m_ptr  = (w + 1) % 4;
            m_held = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e_gnt;
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        vectors++;
        assert (gnt === e_gnt) else begin
            miscompares++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e_gnt);
        end
        assert (gnt_vld === (m_owner >= 0)) else begin
            miscompares++;
            $error("FAIL %s gnt_vld observed=%b expected=%b", tag, gnt_vld, (m_owner >= 0));
        end
        assert (expire === m_exp) else begin
            miscompares++;
            $error("FAIL %s expire observed=%b expected=%b", tag, expire, m_exp);
        end
        if (m_owner >= 0) begin
            assert (gnt_id === 2'(m_owner)) else begin
                miscompares++;
                $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, m_owner);
            end
        end
        if (expire === 1'b1) exp_pulses++;
    endtask

    task automatic step(input logic [3:0] r, input logic rn, input string tag);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        model_edge(r, rn);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] e);
        assert (gnt === e) else begin
            miscompares++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e);
        end
    endtask

    initial begin
        logic [3:0] r;
        logic       rn;
        @(negedge clk);

        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, "reset_hold");
        expect_gnt("reset_gnt", 4'b0000);
        step(4'b1111, 1'b1, "reset_release");
        expect_gnt("first_grant", 4'b0001);

        step(4'b1111, 1'b1, "rot_hold0");
        step(4'b1110, 1'b1, "rot_drop0");
        expect_gnt("rot_to1", 4'b0010);
        step(4'b1111, 1'b1, "rot_hold1");
        step(4'b1101, 1'b1, "rot_drop1");
        expect_gnt("rot_to2", 4'b0100);
        step(4'b1111, 1'b1, "rot_hold2");
        step(4'b1011, 1'b1, "rot_drop2");
        expect_gnt("rot_to3", 4'b1000);
        step(4'b1111, 1'b1, "rot_hold3");
        step(4'b0111, 1'b1, "rot_drop3");
        expect_gnt("rot_to0", 4'b0001);

        step(4'b0011, 1'b1, "bubble_hold");
        step(4'b0010, 1'b1, "bubble_handover");
        expect_gnt("bubble_gnt", 4'b0010);

        step(4'b0100, 1'b1, "ptr_to2");
        expect_gnt("ptr_gnt2", 4'b0100);
        step(4'b1111, 1'b1, "ptr_hold2");
        step(4'b1011, 1'b1, "ptr_drop2");
        expect_gnt("ptr_gnt3", 4'b1000);
        step(4'b0011, 1'b1, "ptr_drop3");
        expect_gnt("ptr_gnt0", 4'b0001);

        exp_pulses = 0;
        for (int i = 0; i < 16; i++) step(4'b0011, 1'b1, "timeout_pair");
        assert (exp_pulses == (TIMEOUT ? 4 : 0)) else begin
            miscompares++;
            $error("FAIL timeout_pulses observed=%0d expected=%0d", exp_pulses, (TIMEOUT ? 4 : 0));
        end
        exp_pulses = 0;
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b1, "timeout_alone");
        assert (exp_pulses == 0) else begin
            miscompares++;
            $error("FAIL timeout_alone_pulses observed=%0d expected=0", exp_pulses);
        end
        expect_gnt("timeout_alone_gnt", 4'b0001);

        step(4'b0100, 1'b1, "midrst_grant2");
        expect_gnt("midrst_gnt2", 4'b0100);
        step(4'b0100, 1'b0, "midrst_reset");
        expect_gnt("midrst_cleared", 4'b0000);
        step(4'b1111, 1'b1, "midrst_ptr0");
        expect_gnt("midrst_from_ptr0", 4'b0001);

        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            rn = ($urandom_range(49) != 0);
            step(r, rn, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter that shares one downstream resource, such as a decoded select bus, between requesters. It samples a 4-bit request vector each cycle, keeps one registered grant until the owner releases it, and drives the one-hot grant through a 2-to-4 grant decoder. An optional hold-timeout forces rotation when another requester is waiting. The arbiter sits between the requesting agents and the shared resource's select lines.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester is pending. Legal range 2..256. Used only with `ARB_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  4  request vector; bit i set means requester i wants, or holds, the resource.
- `gnt`  out  4  one-hot grant; all zero when idle.
- `gnt_id`  out  2  index of the current owner; valid only when `gnt_vld` is high.
- `gnt_vld`  out  1  a grant is active.
- `expire`  out  1  one-cycle pulse when a grant is forcibly revoked by timeout.

## Operation
- Reset values: `gnt` = 0000, `gnt_id` = 0, `gnt_vld` = 0, `expire` = 0, state IDLE, pointer `ptr` = 0, `hold_cnt` = 0.
- State machine has two states, IDLE and BUSY.
- IDLE → BUSY: when `req` != 0 at an edge, grant the first set bit found in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load `gnt_id` with that index and set `gnt_vld` = 1.
  - `ptr` <= winner+1 (mod 4; 3 wraps to 0).
  - `hold_cnt` <= 0.
- BUSY, owner still requesting (`req[gnt_id]` = 1): hold the grant; `hold_cnt` increments and saturates at MAX_HOLD-1.
- BUSY, owner dropped its request (`req[gnt_id]` = 0):
  - If other requests are pending, re-arbitrate from `ptr` in the same edge. This is a direct handover with no idle cycle.
  - Otherwise clear `gnt_vld` and return to IDLE.
- A requester that releases and immediately re-requests gets lowest priority, because `ptr` has already moved past it.
- `gnt` = decode(`gnt_id`) gated by `gnt_vld`. It is combinational from registers only and never from `req`, so at most one bit is ever set.
- Simultaneous requests are resolved only by `ptr` order; there is no fixed priority.

## Timing
- Grant latency is one cycle: `req` sampled high at edge k gives `gnt` high after edge k.
- Release latency is one cycle: owner `req` sampled low at edge k gives `gnt` changed after edge k.
- Handover: old grant bit falls and new grant bit rises after the same edge; `gnt_vld` stays 1.
- Reset mid-grant: `rst_n` low at any edge forces every output to its reset value after that edge and drops any grant immediately.
- Requests that rise and fall between edges are not seen.

## Configuration
- Feature macro: `ARB_TIMEOUT_EN`.
- With `ARB_TIMEOUT_EN` defined:
  - In BUSY, if `hold_cnt` == MAX_HOLD-1 and (`req` & ~`gnt`) != 0 at an edge, revoke the grant.
  - Re-arbitrate from `ptr` and pulse `expire` for exactly one cycle, aligned with the new `gnt`.
  - The owner therefore holds the grant for exactly MAX_HOLD cycles.
  - If nobody else is pending, the counter saturates and the grant persists.
- Without `ARB_TIMEOUT_EN`:
  - No `hold_cnt` register exists and `MAX_HOLD` is ignored.
  - `expire` is tied to 0.
  - A grant lasts until the owner releases it.

## Structure
- Shared package `arb_pkg` holds:
  - `NREQ` = 4 and `ID_W` = 2.
  - The state enum (IDLE, BUSY).
  - A rotating first-set function that takes a 4-bit vector and a 2-bit start index and returns a 2-bit index plus a found flag.
- Sub-module `arb_gnt_dec`: combinational 2-to-4 decoder with enable. It maps (`gnt_id`, `gnt_vld`) to `gnt`.

## Test plan
- Reset: hold `rst_n`=0 with `req`=1111 for 3 cycles. Required: `gnt`=0000, `gnt_vld`=0, `expire`=0 throughout. At the first edge with `rst_n`=1, `gnt` becomes 0001 and `gnt_id` becomes 0.
- Rotation: `req`=1111, and each owner drops its bit for one cycle after 2 grant cycles, then re-raises it. Required: grant order 0,1,2,3,0 with `gnt` always one-hot.
- Zero-bubble handover: with `gnt`=0001, `req` goes from 0011 to 0010. Required: after the next edge, `gnt`=0010 and `gnt_vld` never drops.
- Pointer: requester 2 is granted and then releases, with `req`=1011 pending. Required: `gnt`=1000 next, then 0001 after owner 3 releases.
- Timeout (macro on, MAX_HOLD=4): `req`=0011 held constantly. Required: `gnt`=0001 for 4 cycles, then `expire` pulses once with `gnt`=0010 for 4 cycles, repeating. With `req`=0001 alone, no expire and the grant persists. Macro off: `gnt`=0001 indefinitely and `expire`=0.
- Reset mid-grant: `rst_n`=0 for one edge while `gnt`=0100. Required: all outputs at reset values after that edge. The next grant search starts from `ptr`=0.
